// File: rtl/output_normalize_cdf.sv
// output_normalize_cdf: maps a CDF value to an equalised 8-bit pixel.
// A serial divider computes the per-frame scale; a 3-stage multiply/round pipeline applies it.
module output_normalize_cdf (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] DataIn,
  input  logic        StartIn,
  input  logic [19:0] CdfMin,
  input  logic [19:0] PixelCount,
  input  logic        ConfigValid,
  output logic        ScaleReady,
  output logic        Degenerate,
  output logic        DropError,
  output logic [7:0]  DataOut,
  output logic        StartOut
);
  typedef enum logic [1:0] {IDLE, DIVIDE, READY} state_t;
  localparam logic [23:0] NUM = 24'hFF0000;
  state_t      state_q, state_d;
  logic [19:0] d_q, d_d, cmin_q, cmin_d, diff_q, diff_d;
  logic [20:0] rem_q, rem_d;
  logic [23:0] quo_q, quo_d, scale_q, scale_d, sc1_q, sc1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        degen_q, degen_d, drop_q, drop_d;
  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [43:0] prod_q, prod_d;
  logic [7:0]  dout_q, dout_d;
  logic [21:0] sh;
  logic [28:0] r;
  logic        ge, accept;
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cmin_d  = cmin_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    scale_d = scale_q;
    degen_d = degen_q;
    accept  = StartIn && (state_q == READY);
    sh      = {rem_q, NUM[5'd23 - cnt_q]};
    ge      = sh >= 22'(d_q);
    if (ConfigValid && state_q != DIVIDE) begin
      if (PixelCount > CdfMin) begin
        state_d = DIVIDE;
        d_d     = PixelCount - CdfMin;
        cmin_d  = CdfMin;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = READY;
        scale_d = '0;
        degen_d = 1'b1;
      end
    end else if (state_q == DIVIDE) begin
      rem_d = ge ? 21'(sh - 22'(d_q)) : sh[20:0];
      quo_d = {quo_q[22:0], ge};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd23) begin
        scale_d = quo_d;
        degen_d = 1'b0;
        state_d = READY;
      end
    end
    drop_d = drop_q || (StartIn && !accept);
    // Scale travels with the sample so a degenerate reconfig cannot alter samples in flight.
    v1_d   = accept;
    diff_d = (DataIn > cmin_q) ? DataIn - cmin_q : '0;
    sc1_d  = scale_q;
    v2_d   = v1_q;
    prod_d = 44'(diff_q) * 44'(sc1_q);
    r      = 29'((45'(prod_q) + 45'd32768) >> 16);
    v3_d   = v2_q;
    dout_d = !v2_q ? 8'd0 : (r > 29'd255) ? 8'd255 : r[7:0];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      cmin_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      scale_q <= '0;
      degen_q <= 1'b0;
      drop_q  <= 1'b0;
      v1_q    <= 1'b0;
      diff_q  <= '0;
      sc1_q   <= '0;
      v2_q    <= 1'b0;
      prod_q  <= '0;
      v3_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cmin_q  <= cmin_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      scale_q <= scale_d;
      degen_q <= degen_d;
      drop_q  <= drop_d;
      v1_q    <= v1_d;
      diff_q  <= diff_d;
      sc1_q   <= sc1_d;
      v2_q    <= v2_d;
      prod_q  <= prod_d;
      v3_q    <= v3_d;
      dout_q  <= dout_d;
    end
  end
  assign ScaleReady = state_q == READY;
  assign Degenerate = degen_q;
  assign DropError  = drop_q;
  assign DataOut    = dout_q;
  assign StartOut   = v3_q;
endmodule

// File: tb/tb_output_normalize_cdf.sv
// tb_output_normalize_cdf: directed stimulus with a queue scoreboard for output_normalize_cdf.
module tb_output_normalize_cdf;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [19:0] DataIn = '0, CdfMin = '0, PixelCount = '0;
  logic        StartIn = 1'b0, ConfigValid = 1'b0;
  logic        ScaleReady, Degenerate, DropError, StartOut;
  logic [7:0]  DataOut;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_e;
  int          checks = 0, errors = 0;

  output_normalize_cdf dut (
    .clock(clock), .reset_n(reset_n), .DataIn(DataIn), .StartIn(StartIn),
    .CdfMin(CdfMin), .PixelCount(PixelCount), .ConfigValid(ConfigValid),
    .ScaleReady(ScaleReady), .Degenerate(Degenerate), .DropError(DropError),
    .DataOut(DataOut), .StartOut(StartOut)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int model(input int v, input int cm, input int sc);
    longint d, r;
    d = (v > cm) ? longint'(v - cm) : 0;
    r = (d * sc + 32768) >>> 16;
    return (r > 255) ? 255 : int'(r);
  endfunction

  task automatic start_cfg(input logic [19:0] pc, input logic [19:0] cm);
    PixelCount  = pc;
    CdfMin      = cm;
    ConfigValid = 1'b1;
    tick;
    ConfigValid = 1'b0;
  endtask

  task automatic wait_ready(input int lat, input int degen);
    int n = 0;
    while (!ScaleReady && n < 100) begin
      tick;
      n++;
    end
    chk("ready_latency", n, lat);
    chk("scale_ready", int'(ScaleReady), 1);
    chk("degenerate", int'(Degenerate), degen);
  endtask

  task automatic send(input logic [19:0] v, input logic [7:0] e);
    DataIn  = v;
    StartIn = 1'b1;
    exp_q.push_back(e);
    tick;
    StartIn = 1'b0;
    DataIn  = '0;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_all_zero;
    chk("rst_scale_ready", int'(ScaleReady), 0);
    chk("rst_degenerate", int'(Degenerate), 0);
    chk("rst_drop_error", int'(DropError), 0);
    chk("rst_data_out", int'(DataOut), 0);
    chk("rst_start_out", int'(StartOut), 0);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (StartOut) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got StartOut with DataOut=%0d, expected no output", DataOut);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_out", int'(DataOut), int'(mon_e));
        end
      end else if (DataOut != 8'd0) begin
        checks++;
        errors++;
        $display("FAIL idle_data_out: got %0d, expected 0", DataOut);
      end
    end
  end

  initial begin
    int low;
    logic [19:0] v;
    #12;
    check_all_zero();
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick;
    start_cfg(20'd65536, 20'd0);
    DataIn  = 20'd777;
    StartIn = 1'b1;
    tick;
    StartIn = 1'b0;
    chk("drop_during_divide", int'(DropError), 1);
    wait_ready(23, 0);
    send(20'd65536, 8'd255);
    send(20'd32768, 8'd128);
    send(20'd0, 8'd0);
    drain();
    start_cfg(20'd1000, 20'd100);
    wait_ready(24, 0);
    send(20'd1000, 8'd255);
    send(20'd550, 8'd127);
    send(20'd50, 8'd0);
    send(20'd100, 8'd0);
    drain();
    chk("drop_sticky", int'(DropError), 1);
    start_cfg(20'd500, 20'd500);
    wait_ready(0, 1);
    send(20'd500, 8'd0);
    send(20'd700, 8'd0);
    drain();
    start_cfg(20'd65536, 20'd0);
    wait_ready(24, 0);
    low = 0;
    for (int c = 0; c < 40; c++) begin
      v = (c <= 3) ? 20'(16000 * (c + 1)) : 20'(25 * c);
      DataIn  = v;
      StartIn = 1'b1;
      if (c == 3) begin
        ConfigValid = 1'b1;
        PixelCount  = 20'd1000;
        CdfMin      = 20'd100;
      end
      if (c <= 3) exp_q.push_back(8'(model(int'(v), 0, 255)));
      else if (c >= 28) exp_q.push_back(8'(model(int'(v), 100, 18568)));
      if (!ScaleReady) low++;
      tick;
      ConfigValid = 1'b0;
    end
    StartIn = 1'b0;
    drain();
    chk("reconfig_low_cycles", low, 24);
    DataIn      = 20'd1000;
    StartIn     = 1'b1;
    PixelCount  = 20'd1000;
    CdfMin      = 20'd100;
    ConfigValid = 1'b1;
    tick;
    StartIn     = 1'b0;
    ConfigValid = 1'b0;
    tick;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero();
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick;
    tick;
    tick;
    chk("idle_after_reset", int'(ScaleReady), 0);
    chk("drop_cleared", int'(DropError), 0);
    DataIn  = 20'd42;
    StartIn = 1'b1;
    tick;
    StartIn = 1'b0;
    tick;
    chk("drop_idle", int'(DropError), 1);
    start_cfg(20'd65536, 20'd0);
    wait_ready(24, 0);
    send(20'd32768, 8'd128);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
